calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - four-step operand/opcode entry sequencer with latched ALU result
// Optional accumulator chaining from RESULT back to IN_B is enabled by defining CALC_CHAIN_EN.
module calc_sequencer #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_next,
    input  logic               btn_clear,
    input  logic [WIDTH-1:0]   sw,
    output logic [2*WIDTH-1:0] display_val,
    output logic [3:0]         state_led,
    output logic [2:0]         flags,
    output logic               result_valid
);

    typedef enum logic [1:0] {
        IN_A   = 2'd0,
        IN_B   = 2'd1,
        OP     = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_NOT = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL = OPW'(6);
    localparam logic [OPW-1:0] OP_SHR = OPW'(7);
    localparam logic [4:0]     W5     = 5'(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             btn_prev;
    logic             next_pulse;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic [2:0]       flag_reg;

    logic             load_a;
    logic             load_b;
    logic             load_res;
    logic             clr_all;
    logic             chain;

    logic [OPW-1:0]   opcode;
    logic [3:0]       amt;
    logic             amt_big;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign next_pulse = btn_next & ~btn_prev;
    assign opcode     = sw[OPW-1:0];
    assign amt        = op_b[3:0];
    assign amt_big    = ({1'b0, amt} >= W5);
    assign sum_ext    = {1'b0, op_a} + {1'b0, op_b};
    assign diff_ext   = {1'b0, op_a} - {1'b0, op_b};
    // Extra bit on the far side of each shift catches the last bit shifted out.
    assign shl_ext    = {1'b0, op_a} << amt;
    assign shr_ext    = {op_a, 1'b0} >> amt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_NOT: alu_res = ~op_a;
            OP_SHL: begin
                if (!amt_big) begin
                    alu_res = shl_ext[WIDTH-1:0];
                    alu_c   = shl_ext[WIDTH];
                end
            end
            OP_SHR: begin
                if (!amt_big) begin
                    alu_res = shr_ext[WIDTH:1];
                    alu_c   = shr_ext[0];
                end
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_res   = 1'b0;
        clr_all    = 1'b0;
        chain      = 1'b0;
        if (btn_clear) begin
            state_next = IN_A;
            clr_all    = 1'b1;
        end else if (next_pulse) begin
            case (state)
                IN_A: begin
                    state_next = IN_B;
                    load_a     = 1'b1;
                end
                IN_B: begin
                    state_next = OP;
                    load_b     = 1'b1;
                end
                OP: begin
                    state_next = RESULT;
                    load_res   = 1'b1;
                end
                RESULT: begin
`ifdef CALC_CHAIN_EN
                    state_next = IN_B;
                    chain      = 1'b1;
`else
                    state_next = RESULT;
`endif
                end
                default: state_next = IN_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IN_A;
            btn_prev <= 1'b1;
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
            flag_reg <= 3'b000;
        end else begin
            state    <= state_next;
            btn_prev <= btn_next;
            if (clr_all) begin
                op_a     <= '0;
                op_b     <= '0;
                result   <= '0;
                flag_reg <= 3'b000;
            end else begin
                if (load_a) op_a <= sw;
                if (load_b) op_b <= sw;
                if (load_res) begin
                    result   <= alu_res;
                    flag_reg <= {alu_c, alu_v, (alu_res == '0)};
                end
                if (chain) begin
                    op_a     <= result;
                    op_b     <= '0;
                    flag_reg <= 3'b000;
                end
            end
        end
    end

    always_comb begin
        state_led = 4'b0001;
        case (state)
            IN_A:    state_led = 4'b0001;
            IN_B:    state_led = 4'b0010;
            OP:      state_led = 4'b0100;
            RESULT:  state_led = 4'b1000;
            default: state_led = 4'b0001;
        endcase
    end

    assign result_valid = (state == RESULT);
    assign flags        = result_valid ? flag_reg : 3'b000;
    assign display_val  = result_valid ? {{WIDTH{1'b0}}, result} : {op_b, op_a};

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - scoreboard bench for calc_sequencer with an arithmetic reference model
module tb_calc_sequencer;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           btn_next;
    logic           btn_clear;
    logic [W-1:0]   sw;
    logic [2*W-1:0] display_val;
    logic [3:0]     state_led;
    logic [2:0]     flags;
    logic           result_valid;

    typedef struct packed {
        logic [2*W-1:0] disp;
        logic [2:0]     flg;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_valid = 1'b0;

    calc_sequencer #(.WIDTH(W), .OPW(3)) dut (
        .clk(clk),
        .rst(rst),
        .btn_next(btn_next),
        .btn_clear(btn_clear),
        .sw(sw),
        .display_val(display_val),
        .state_led(state_led),
        .flags(flags),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned/signed views of the operands.
    function automatic exp_t model(input int a, input int b, input int op);
        int r, c, v, sa, sb, s, sh;
        exp_t e;
        r = 0; c = 0; v = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 16;
        case (op)
            0: begin r = (a + b) % 256; c = (a + b > 255); s = sa + sb; v = (s > 127 || s < -128); end
            1: begin r = (a - b + 256) % 256; c = (a < b); s = sa - sb; v = (s > 127 || s < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: if (sh < W) begin r = (a * (1 << sh)) % 256; c = (sh == 0) ? 0 : (a >> (W - sh)) % 2; end
            default: if (sh < W) begin r = a >> sh; c = (sh == 0) ? 0 : (a >> (sh - 1)) % 2; end
        endcase
        e.disp = 16'(r);
        e.flg  = {c[0], v[0], (r == 0)};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        tick();
    endtask

    task automatic clear();
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
        tick();
    endtask

    task automatic run_calc(input int a, input int b, input int op, input string name);
        sw = W'(a);
        pulse();
        sw = W'(b);
        pulse();
        sw = W'(op);
        exp_q.push_back(model(a, b, op));
        pulse();
        check({name, " state_led"}, 32'(state_led), 32'h8);
    endtask

    // Monitor: each entry into RESULT consumes one expected response.
    always @(negedge clk) begin
        if (result_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected RESULT entry", 32'(display_val), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("scoreboard display_val", 32'(display_val), 32'(e.disp));
                check("scoreboard flags", 32'(flags), 32'(e.flg));
            end
        end
        prev_valid = result_valid;
    end

    initial begin
        rst       = 1'b1;
        btn_next  = 1'b1;
        btn_clear = 1'b0;
        sw        = '0;
        repeat (3) tick();
        check("reset state_led", 32'(state_led), 32'h1);
        check("reset display_val", 32'(display_val), 32'h0);
        check("reset flags", 32'(flags), 32'h0);
        check("reset result_valid", 32'(result_valid), 32'h0);

        // Button held through reset release must not advance.
        sw  = 8'h55;
        rst = 1'b0;
        repeat (3) tick();
        check("held btn after reset state", 32'(state_led), 32'h1);
        check("held btn after reset display", 32'(display_val), 32'h0);
        btn_next = 1'b0;
        tick();
        check("btn released state", 32'(state_led), 32'h1);

        // 05 + 03 -> 0x0008
        sw = 8'h05;
        pulse();
        check("after A state", 32'(state_led), 32'h2);
        check("after A display", 32'(display_val), 32'h0005);
        sw = 8'h03;
        pulse();
        check("after B state", 32'(state_led), 32'h4);
        check("after B display", 32'(display_val), 32'h0305);
        sw = 8'h00;
        exp_q.push_back(model(5, 3, 0));
        pulse();
        check("add state_led", 32'(state_led), 32'h8);
        check("add result_valid", 32'(result_valid), 32'h1);

        // Pulse inside RESULT: hold by default, chain when enabled.
        pulse();
`ifdef CALC_CHAIN_EN
        check("chain state", 32'(state_led), 32'h2);
        check("chain display", 32'(display_val), 32'h0008);
        check("chain flags", 32'(flags), 32'h0);
        sw = 8'h02;
        pulse();
        sw = 8'h01;
        exp_q.push_back(model(8, 2, 1));
        pulse();
        check("chain sub state", 32'(state_led), 32'h8);
`else
        check("RESULT hold state", 32'(state_led), 32'h8);
        check("RESULT hold display", 32'(display_val), 32'h0008);
        check("RESULT hold flags", 32'(flags), 32'h0);
`endif
        clear();
        check("clear state", 32'(state_led), 32'h1);
        check("clear display", 32'(display_val), 32'h0);

        // Clear wins over a simultaneous next edge.
        sw = 8'h2A;
        pulse();
        check("capture 2A display", 32'(display_val), 32'h002A);
        btn_clear = 1'b1;
        btn_next  = 1'b1;
        tick();
        check("clear+next state", 32'(state_led), 32'h1);
        check("clear+next display", 32'(display_val), 32'h0);
        btn_clear = 1'b0;
        btn_next  = 1'b0;
        tick();
        check("clear+next no advance", 32'(state_led), 32'h1);

        run_calc(8'hFF, 8'h01, 0, "FF+01");
        clear();
        run_calc(8'h03, 8'h05, 1, "03-05");
        clear();
        run_calc(8'h7F, 8'h01, 0, "7F+01");
        clear();
        run_calc(8'h81, 8'h00, 6, "SHL by 0");
        clear();
        run_calc(8'h81, 8'h08, 7, "SHR by 8");
        clear();
        run_calc(8'hC3, 8'h07, 6, "SHL by 7");
        clear();
        run_calc(8'h80, 8'h01, 1, "80-01");
        clear();

        for (int i = 0; i < 60; i++) begin
            int a, b, op;
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            op = int'($urandom_range(0, 7));
            if (op >= 6 && ($urandom_range(0, 1) == 1)) b = int'($urandom_range(0, 15));
            run_calc(a, b, op, "random");
            clear();
            check("random clear state", 32'(state_led), 32'h1);
        end

        repeat (3) tick();
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
